// File: rtl/drivetrain_core.sv
// drivetrain_core
//   Gearbox, engine and odometer for one car. A free-running divider produces
//   a one-cycle physics tick; a gear FSM with a timed clutch phase integrates
//   rpm per tick, converts rpm to a per-tick position increment, and
//   accumulates position with saturation.
//
//   Optional feature macro: DRIVETRAIN_AUTO_SHIFT_EN
//     defined   : in RUN, a tick with throttle applied at or above the rev
//                 limit (and not in top gear) performs an upshift instead of
//                 the rpm update. Manual shifting still works.
//     undefined : manual shifting only.
//
// Ports
//   clk                       system clock
//   rst                       synchronous reset, active-low
//   reset_status              race restart, synchronous active-high, same effect as rst
//   enable_controller_status  1 = driver inputs live, 0 = gas/shift masked
//   gas                       throttle level
//   shift_up_tick             one-cycle upshift request
//   gear                      current gear, 0 = first
//   rpm                       engine rpm
//   d_position                position increment per tick
//   position                  distance travelled (saturating)
//   shifting                  high while the clutch phase is active
//   rev_limit                 rpm at or above RPM_LIMIT
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset; rpm at idle, position frozen, waits for enable
// RUN    | rpm follows throttle each tick, upshifts accepted
// SHIFT  | clutch engaged for SHIFT_TICKS ticks; rpm decays, gas ignored

module drivetrain_core #(
   parameter int GEARS       = 4,
   parameter int TICK_DIV    = 1000000,
   parameter int RPM_W       = 14,
   parameter int RPM_IDLE    = 1000,
   parameter int RPM_MAX     = 9000,
   parameter int RPM_LIMIT   = 8000,
   parameter int RPM_UP      = 100,
   parameter int RPM_DOWN    = 50,
   parameter int SHIFT_TICKS = 10,
   parameter int DPOS_W      = 5,
   parameter int DPOS_SHIFT  = 11,
   parameter int POS_W       = 32,
   localparam int GEAR_W     = $clog2(GEARS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reset_status,
   input  logic              enable_controller_status,
   input  logic              gas,
   input  logic              shift_up_tick,
   output logic [GEAR_W-1:0] gear,
   output logic [RPM_W-1:0]  rpm,
   output logic [DPOS_W-1:0] d_position,
   output logic [POS_W-1:0]  position,
   output logic              shifting,
   output logic              rev_limit
);

   localparam int TICK_W   = $clog2(TICK_DIV);
   localparam int CLUTCH_W = $clog2(SHIFT_TICKS + 1);
   localparam int PROD_W   = RPM_W + GEAR_W + 1;

   localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK_DIV - 1);
   localparam logic [CLUTCH_W-1:0] CLUTCH_LOAD = CLUTCH_W'(SHIFT_TICKS);
   localparam logic [GEAR_W-1:0]   GEAR_TOP    = GEAR_W'(GEARS - 1);
   localparam logic [RPM_W-1:0]    RPM_IDLE_V  = RPM_W'(RPM_IDLE);
   localparam logic [RPM_W-1:0]    RPM_LIMIT_V = RPM_W'(RPM_LIMIT);
   localparam logic [RPM_W:0]      RPM_MAX_X   = (RPM_W+1)'(RPM_MAX);
   localparam logic [RPM_W:0]      RPM_UP_X    = (RPM_W+1)'(RPM_UP);
   localparam logic [RPM_W:0]      RPM_DEC_MIN = (RPM_W+1)'(RPM_IDLE + RPM_DOWN);
   localparam logic [RPM_W-1:0]    RPM_DOWN_V  = RPM_W'(RPM_DOWN);
   localparam logic [PROD_W-1:0]   DPOS_MAX_X  = PROD_W'((64'd1 << DPOS_W) - 64'd1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [TICK_W-1:0]   tick_cnt, tick_nxt;
   logic [CLUTCH_W-1:0] clutch_cnt, clutch_nxt;
   logic [GEAR_W-1:0]   gear_nxt;
   logic [RPM_W-1:0]    rpm_nxt;
   logic [DPOS_W-1:0]   dpos_nxt;
   logic [POS_W-1:0]    pos_nxt;

   logic                tick;
   logic                drive_gas;
   logic                shift_req;
   logic                auto_req;
   logic [RPM_W:0]      rpm_up_sum;
   logic [RPM_W-1:0]    rpm_inc;
   logic [RPM_W-1:0]    rpm_dec;
   logic [RPM_W-1:0]    rpm_clutch_drop;
   logic [RPM_W-1:0]    rpm_shift;
   logic [PROD_W-1:0]   speed_prod;
   logic [PROD_W-1:0]   dpos_raw;
   logic [DPOS_W-1:0]   dpos_calc;
   logic [POS_W:0]      pos_sum;
   logic [POS_W-1:0]    pos_sat;

   assign shifting  = (state == ST_SHIFT);
   assign rev_limit = (rpm >= RPM_LIMIT_V);

   // Datapath candidates, all computed from the current (pre-update) registers.
   always_comb begin
      tick            = (tick_cnt == TICK_LAST);
      drive_gas       = gas & enable_controller_status;
      rpm_up_sum      = {1'b0, rpm} + (RPM_UP_X >> gear);
      rpm_inc         = (rpm_up_sum > RPM_MAX_X) ? RPM_W'(RPM_MAX) : rpm_up_sum[RPM_W-1:0];
      rpm_dec         = ({1'b0, rpm} >= RPM_DEC_MIN) ? (rpm - RPM_DOWN_V) : RPM_IDLE_V;
      rpm_clutch_drop = rpm - (rpm >> 2);
      rpm_shift       = (rpm_clutch_drop < RPM_IDLE_V) ? RPM_IDLE_V : rpm_clutch_drop;
      speed_prod      = PROD_W'(rpm) * (PROD_W'(gear) + PROD_W'(1));
      dpos_raw        = speed_prod >> DPOS_SHIFT;
      dpos_calc       = (dpos_raw > DPOS_MAX_X) ? DPOS_W'(DPOS_MAX_X) : DPOS_W'(dpos_raw);
      pos_sum         = {1'b0, position} + (POS_W+1)'(d_position);
      pos_sat         = pos_sum[POS_W] ? '1 : pos_sum[POS_W-1:0];
   end

   always_comb begin
      state_nxt  = state;
      gear_nxt   = gear;
      rpm_nxt    = rpm;
      dpos_nxt   = d_position;
      pos_nxt    = position;
      clutch_nxt = clutch_cnt;
      tick_nxt   = tick ? '0 : tick_cnt + TICK_W'(1);

      shift_req  = enable_controller_status & shift_up_tick & (gear < GEAR_TOP);
      auto_req   = 1'b0;
`ifdef DRIVETRAIN_AUTO_SHIFT_EN
      auto_req   = tick & drive_gas & rev_limit & (gear < GEAR_TOP);
`endif

      case (state)
         ST_IDLE: begin
            if (enable_controller_status) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (tick) begin
               dpos_nxt = dpos_calc;
               pos_nxt  = pos_sat;
            end
            // An accepted shift pre-empts the tick's rpm update on the same edge.
            if (shift_req || auto_req) begin
               gear_nxt   = gear + GEAR_W'(1);
               rpm_nxt    = rpm_shift;
               clutch_nxt = CLUTCH_LOAD;
               state_nxt  = ST_SHIFT;
            end else if (tick) begin
               rpm_nxt = drive_gas ? rpm_inc : rpm_dec;
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               dpos_nxt   = dpos_calc;
               pos_nxt    = pos_sat;
               rpm_nxt    = rpm_dec;
               clutch_nxt = clutch_cnt - CLUTCH_W'(1);
               if (clutch_cnt == CLUTCH_W'(1)) state_nxt = ST_RUN;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst || reset_status) begin
         state      <= ST_IDLE;
         gear       <= '0;
         rpm        <= RPM_IDLE_V;
         d_position <= '0;
         position   <= '0;
         tick_cnt   <= '0;
         clutch_cnt <= '0;
      end else begin
         state      <= state_nxt;
         gear       <= gear_nxt;
         rpm        <= rpm_nxt;
         d_position <= dpos_nxt;
         position   <= pos_nxt;
         tick_cnt   <= tick_nxt;
         clutch_cnt <= clutch_nxt;
      end
   end

endmodule
